lsu_arbiter: RTL and testbench

- Shares the single load/store unit port between two requesters.
- Port 0 is the pipeline MEM stage. Port 1 is the debug/boot-loader master.
- Arbitrates every cycle and drives the LSU request lines combinationally from the winner.
- Tracks in-flight accesses with an owner-tag shift register, so each LSU read-data return is steered to the requester that issued it.

---
 rtl/lsu_arb_pkg.sv | 22 ++
 rtl/lsu_arbiter_if.sv | 47 ++++
 rtl/lsu_arb_core.sv | 91 +++++++++
 rtl/lsu_arbiter.sv | 110 +++++++++++
 tb/tb_lsu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU port arbiter.
// Owner ids, in-flight tag layout and the LSU byte-mask/size codes.
package lsu_arb_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t owner;
    } tag_t;

    // Byte-mask / size codes understood by the LSU (bit 2 = zero-extend load).
    localparam logic [2:0] BMASK_BYTE   = 3'b000;
    localparam logic [2:0] BMASK_HALF   = 3'b001;
    localparam logic [2:0] BMASK_WORD   = 3'b010;
    localparam logic [2:0] BMASK_BYTE_U = 3'b100;
    localparam logic [2:0] BMASK_HALF_U = 3'b101;

endpackage

// File: rtl/lsu_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the LSU.
// slave: arbiter side; master: requesters plus LSU model side.
interface lsu_arbiter_if;

    logic        i_p0_req;
    logic [31:0] i_p0_addr;
    logic [31:0] i_p0_wdata;
    logic        i_p0_wren;
    logic [2:0]  i_p0_bmask;
    logic        o_p0_gnt;
    logic        o_p0_rvalid;
    logic [31:0] o_p0_rdata;

    logic        i_p1_req;
    logic [31:0] i_p1_addr;
    logic [31:0] i_p1_wdata;
    logic        i_p1_wren;
    logic [2:0]  i_p1_bmask;
    logic        o_p1_gnt;
    logic        o_p1_rvalid;
    logic [31:0] o_p1_rdata;

    logic [31:0] o_lsu_addr;
    logic [31:0] o_lsu_st_data;
    logic        o_lsu_wren;
    logic [2:0]  o_lsu_bmask;
    logic [31:0] i_lsu_ld_data;

    modport slave (
        input  i_p0_req, i_p0_addr, i_p0_wdata, i_p0_wren, i_p0_bmask,
        output o_p0_gnt, o_p0_rvalid, o_p0_rdata,
        input  i_p1_req, i_p1_addr, i_p1_wdata, i_p1_wren, i_p1_bmask,
        output o_p1_gnt, o_p1_rvalid, o_p1_rdata,
        output o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_bmask,
        input  i_lsu_ld_data
    );

    modport master (
        output i_p0_req, i_p0_addr, i_p0_wdata, i_p0_wren, i_p0_bmask,
        input  o_p0_gnt, o_p0_rvalid, o_p0_rdata,
        output i_p1_req, i_p1_addr, i_p1_wdata, i_p1_wren, i_p1_bmask,
        input  o_p1_gnt, o_p1_rvalid, o_p1_rdata,
        input  o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_bmask,
        output i_lsu_ld_data
    );

endinterface

// File: rtl/lsu_arb_core.sv
// Grant decision for the two LSU requesters.
// Default: round-robin on contention using last_gnt.
// LSU_ARB_FIXED_PRIO_EN: port 0 wins contention unless port 1 has been
// denied STARVE_LIM consecutive requesting cycles.
module lsu_arb_core
    import lsu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_p0_req,
    input  logic     i_p1_req,
    output logic     o_p0_gnt,
    output logic     o_p1_gnt,
    output port_id_t o_winner
);

    if (STARVE_LIM < 1) begin : g_bad_lim
        $error("lsu_arb_core: STARVE_LIM must be at least 1");
    end

    logic p1_pri;

`ifdef LSU_ARB_FIXED_PRIO_EN
    localparam int unsigned     CW  = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0]   LIM = CW'(STARVE_LIM);

    logic [CW-1:0] starve_q, starve_d;

    assign p1_pri = (starve_q >= LIM);

    // Saturating count of denied port 1 requesting cycles.
    always_comb begin
        starve_d = starve_q;
        if (o_p1_gnt) begin
            starve_d = '0;
        end else if (i_p1_req && (starve_q != LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    port_id_t last_gnt_q, last_gnt_d;

    assign p1_pri = (last_gnt_q == PORT_CPU);

    // Remember the most recent winner; idle cycles leave it untouched.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (o_p0_gnt || o_p1_gnt) begin
            last_gnt_d = o_winner;
        end
    end

    // last_gnt resets to port 1 so port 0 takes the first contention.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_gnt_q <= PORT_DBG;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // Grant decision; suppressed entirely while reset is asserted.
    always_comb begin
        o_p0_gnt = 1'b0;
        o_p1_gnt = 1'b0;
        if (i_reset) begin
            if (i_p0_req && i_p1_req) begin
                o_p0_gnt = !p1_pri;
                o_p1_gnt = p1_pri;
            end else begin
                o_p0_gnt = i_p0_req;
                o_p1_gnt = i_p1_req;
            end
        end
    end

    assign o_winner = o_p1_gnt ? PORT_DBG : PORT_CPU;

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of the single LSU port.
// Port 0: pipeline MEM stage, port 1: debug/boot-loader master.
// Requests are muxed to the LSU combinationally; an owner-tag shift register
// of RD_LAT (1..4) stages steers each response back to its issuer.
// Optional macro LSU_ARB_FIXED_PRIO_EN selects fixed priority with
// starvation relief (see lsu_arb_core).
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_LIM = 8
) (
    input logic          i_clk,
    input logic          i_reset,
    lsu_arbiter_if.slave bus
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("lsu_arbiter: RD_LAT must be in 1..4");
    end

    logic     p0_gnt, p1_gnt, gnt_any;
    port_id_t winner;

    logic [31:0] lsu_addr, lsu_st_data;
    logic        lsu_wren;
    logic [2:0]  lsu_bmask;

    tag_t [RD_LAT-1:0] tag_q, tag_d;
    logic [RD_LAT-1:0] wr_q, wr_d;
    tag_t              tail;
    logic              tail_wr;

    lsu_arb_core #(
        .STARVE_LIM (STARVE_LIM)
    ) u_core (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_p0_req (bus.i_p0_req),
        .i_p1_req (bus.i_p1_req),
        .o_p0_gnt (p0_gnt),
        .o_p1_gnt (p1_gnt),
        .o_winner (winner)
    );

    assign gnt_any = p0_gnt || p1_gnt;

    // LSU request mux; all-zero when nobody holds the grant.
    always_comb begin
        lsu_addr    = '0;
        lsu_st_data = '0;
        lsu_wren    = 1'b0;
        lsu_bmask   = '0;
        if (p0_gnt) begin
            lsu_addr    = bus.i_p0_addr;
            lsu_st_data = bus.i_p0_wdata;
            lsu_wren    = bus.i_p0_wren;
            lsu_bmask   = bus.i_p0_bmask;
        end else if (p1_gnt) begin
            lsu_addr    = bus.i_p1_addr;
            lsu_st_data = bus.i_p1_wdata;
            lsu_wren    = bus.i_p1_wren;
            lsu_bmask   = bus.i_p1_bmask;
        end
    end

    // Shift in this cycle's issue tag; the write flag rides alongside so the
    // owner receives a zero-data ack instead of load data for stores.
    always_comb begin
        tag_d          = tag_q;
        wr_d           = wr_q;
        tag_d[0].valid = gnt_any;
        tag_d[0].owner = winner;
        wr_d[0]        = lsu_wren;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
            wr_d[i]  = wr_q[i-1];
        end
    end

    // Tag pipe register; reset discards anything in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tag_q <= '0;
            wr_q  <= '0;
        end else begin
            tag_q <= tag_d;
            wr_q  <= wr_d;
        end
    end

    assign tail    = tag_q[RD_LAT-1];
    assign tail_wr = wr_q[RD_LAT-1];

    // Response steering from the tail of the tag pipe.
    always_comb begin
        bus.o_p0_rvalid = tail.valid && (tail.owner == PORT_CPU);
        bus.o_p1_rvalid = tail.valid && (tail.owner == PORT_DBG);
        bus.o_p0_rdata  = (bus.o_p0_rvalid && !tail_wr) ? bus.i_lsu_ld_data : '0;
        bus.o_p1_rdata  = (bus.o_p1_rvalid && !tail_wr) ? bus.i_lsu_ld_data : '0;
    end

    assign bus.o_p0_gnt      = p0_gnt;
    assign bus.o_p1_gnt      = p1_gnt;
    assign bus.o_lsu_addr    = lsu_addr;
    assign bus.o_lsu_st_data = lsu_st_data;
    assign bus.o_lsu_wren    = lsu_wren;
    assign bus.o_lsu_bmask   = lsu_bmask;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: two instances (RD_LAT=1 and RD_LAT=3)
// share one stimulus stream; grants and LSU drive are predicted per cycle,
// responses are queued at issue and popped when due.
`timescale 1ns/1ps
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam int unsigned STARVE_LIM = 8;

    typedef struct {
        int unsigned due;
        int unsigned port;
        logic        wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_arbiter_if bus1();
    lsu_arbiter_if bus3();

    lsu_arbiter #(.RD_LAT(1), .STARVE_LIM(STARVE_LIM)) u_dut1 (
        .i_clk (clk), .i_reset (rst_n), .bus (bus1)
    );
    lsu_arbiter #(.RD_LAT(3), .STARVE_LIM(STARVE_LIM)) u_dut3 (
        .i_clk (clk), .i_reset (rst_n), .bus (bus3)
    );

    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        wren  [2];
    logic [2:0]  bmask [2];
    logic [31:0] ld_data;
    logic        ld_ovr;
    logic [31:0] ld_ovr_val;

    exp_t sb1[$];
    exp_t sb3[$];

    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    int unsigned m_last;
    int unsigned m_starve;

    logic        last_wv;
    int unsigned last_w;
    logic        obs_p1gnt;
    logic        obs_wren1;
    logic        obs_wren3;
    logic [31:0] obs_rd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_fn(input int unsigned c);
        logic [31:0] cv;
        cv = c;
        return 32'h5A00_0000 ^ {cv[15:0], ~cv[15:0]};
    endfunction

    task automatic apply();
        bus1.i_p0_req = req[0];   bus3.i_p0_req = req[0];
        bus1.i_p0_addr = addr[0]; bus3.i_p0_addr = addr[0];
        bus1.i_p0_wdata = wdata[0]; bus3.i_p0_wdata = wdata[0];
        bus1.i_p0_wren = wren[0]; bus3.i_p0_wren = wren[0];
        bus1.i_p0_bmask = bmask[0]; bus3.i_p0_bmask = bmask[0];
        bus1.i_p1_req = req[1];   bus3.i_p1_req = req[1];
        bus1.i_p1_addr = addr[1]; bus3.i_p1_addr = addr[1];
        bus1.i_p1_wdata = wdata[1]; bus3.i_p1_wdata = wdata[1];
        bus1.i_p1_wren = wren[1]; bus3.i_p1_wren = wren[1];
        bus1.i_p1_bmask = bmask[1]; bus3.i_p1_bmask = bmask[1];
        bus1.i_lsu_ld_data = ld_data; bus3.i_lsu_ld_data = ld_data;
    endtask

    task automatic set_req(input int unsigned p, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic we, input logic [2:0] bm);
        req[p] = r; addr[p] = a; wdata[p] = d; wren[p] = we; bmask[p] = bm;
    endtask

    function automatic logic [65:0] exp_resp(input logic hit, input exp_t e, input logic [31:0] ld);
        logic [31:0] d;
        logic [65:0] r;
        r = '0;
        if (hit) begin
            d = e.wr ? 32'h0 : ld;
            if (e.port == 1) r = {2'b10, d, 32'h0};
            else             r = {2'b01, 32'h0, d};
        end
        return r;
    endfunction

    // One cycle: drive at negedge, sample 1ns later, update model, advance.
    task automatic tick();
        logic        both, wv, hit;
        int unsigned w;
        logic [1:0]  eg;
        logic [31:0] ea, es;
        logic [3:0]  ewb;
        exp_t        e;
        logic [65:0] er;
        ld_data = ld_ovr ? ld_ovr_val : ld_fn(cyc);
        ld_ovr  = 1'b0;
        apply();
        #1;
        both = req[0] && req[1];
        wv   = req[0] || req[1];
        if (both) begin
`ifdef LSU_ARB_FIXED_PRIO_EN
            w = (m_starve >= STARVE_LIM) ? 1 : 0;
`else
            w = (m_last == 1) ? 0 : 1;
`endif
        end else begin
            w = req[1] ? 1 : 0;
        end
        eg  = wv ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        ea  = wv ? addr[w] : 32'h0;
        es  = wv ? wdata[w] : 32'h0;
        ewb = wv ? {wren[w], bmask[w]} : 4'h0;

        chk("d1_gnt", 64'({bus1.o_p1_gnt, bus1.o_p0_gnt}), 64'(eg));
        chk("d1_lsu_addr", 64'(bus1.o_lsu_addr), 64'(ea));
        chk("d1_lsu_st", 64'(bus1.o_lsu_st_data), 64'(es));
        chk("d1_lsu_wr_bm", 64'({bus1.o_lsu_wren, bus1.o_lsu_bmask}), 64'(ewb));
        chk("d3_gnt", 64'({bus3.o_p1_gnt, bus3.o_p0_gnt}), 64'(eg));
        chk("d3_lsu_addr", 64'(bus3.o_lsu_addr), 64'(ea));
        chk("d3_lsu_wr_bm", 64'({bus3.o_lsu_wren, bus3.o_lsu_bmask}), 64'(ewb));

        e = '{due: 0, port: 0, wr: 1'b0};
        hit = (sb1.size() > 0) && (sb1[0].due == cyc);
        if (hit) e = sb1.pop_front();
        er = exp_resp(hit, e, ld_data);
        chk("d1_rvalid", 64'({bus1.o_p1_rvalid, bus1.o_p0_rvalid}), 64'(er[65:64]));
        chk("d1_rdata1", 64'(bus1.o_p1_rdata), 64'(er[63:32]));
        chk("d1_rdata0", 64'(bus1.o_p0_rdata), 64'(er[31:0]));

        e = '{due: 0, port: 0, wr: 1'b0};
        hit = (sb3.size() > 0) && (sb3[0].due == cyc);
        if (hit) e = sb3.pop_front();
        er = exp_resp(hit, e, ld_data);
        chk("d3_rvalid", 64'({bus3.o_p1_rvalid, bus3.o_p0_rvalid}), 64'(er[65:64]));
        chk("d3_rdata1", 64'(bus3.o_p1_rdata), 64'(er[63:32]));
        chk("d3_rdata0", 64'(bus3.o_p0_rdata), 64'(er[31:0]));

        obs_p1gnt = bus1.o_p1_gnt;
        obs_wren1 = bus1.o_lsu_wren;
        obs_wren3 = bus3.o_lsu_wren;
        obs_rd0   = bus1.o_p0_rdata;

        if (wv) begin
            e.port = w;
            e.wr   = wren[w];
            e.due  = cyc + 1;
            sb1.push_back(e);
            e.due  = cyc + 3;
            sb3.push_back(e);
            m_last = w;
        end
        if (eg[1]) m_starve = 0;
        else if (req[1] && m_starve < STARVE_LIM) m_starve++;
        last_wv = wv;
        last_w  = w;

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset with requests active; everything must read as zero.
    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, BMASK_WORD);
        set_req(1, 1'b1, 32'h0000_0800, 32'h2222_2222, 1'b1, BMASK_HALF);
        ld_data = 32'hFFFF_FFFF;
        apply();
        #1;
        chk("rst_d1_gnt", 64'({bus1.o_p1_gnt, bus1.o_p0_gnt}), 64'h0);
        chk("rst_d1_lsu", 64'({bus1.o_lsu_addr, bus1.o_lsu_st_data}), 64'h0);
        chk("rst_d1_wr_bm", 64'({bus1.o_lsu_wren, bus1.o_lsu_bmask}), 64'h0);
        chk("rst_d1_rv", 64'({bus1.o_p1_rvalid, bus1.o_p0_rvalid}), 64'h0);
        chk("rst_d1_rd", 64'({bus1.o_p1_rdata, bus1.o_p0_rdata}), 64'h0);
        chk("rst_d3_gnt", 64'({bus3.o_p1_gnt, bus3.o_p0_gnt}), 64'h0);
        chk("rst_d3_lsu", 64'({bus3.o_lsu_addr, bus3.o_lsu_st_data}), 64'h0);
        chk("rst_d3_rv", 64'({bus3.o_p1_rvalid, bus3.o_p0_rvalid}), 64'h0);
        chk("rst_d3_rd", 64'({bus3.o_p1_rdata, bus3.o_p0_rdata}), 64'h0);
        sb1.delete();
        sb3.delete();
        m_last   = 1;
        m_starve = 0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        apply();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        req[0] = 1'b0;
        req[1] = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [3:0]  ord;
        int unsigned wcnt1, wcnt3, p0_run;
        n_checks = 0; n_fail = 0; cyc = 0;
        m_last = 1; m_starve = 0;
        ld_ovr = 1'b0; ld_ovr_val = '0;
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        do_reset();
        idle(1);

        // Continuous contention for four grants, first one after reset.
        set_req(0, 1'b1, 32'h0000_0200, 32'h0, 1'b0, BMASK_WORD);
        set_req(1, 1'b1, 32'h0000_0300, 32'h0, 1'b0, BMASK_WORD);
        ord = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ord = {ord[2:0], obs_p1gnt};
            if (last_w == 0) addr[0] = addr[0] + 32'd4;
            else             addr[1] = addr[1] + 32'd4;
        end
`ifdef LSU_ARB_FIXED_PRIO_EN
        chk("contend_order", 64'(ord), 64'h0);
`else
        chk("contend_order", 64'(ord), 64'b0101);
`endif
        idle(4);

        // Single port 0 read returning 0xDEADBEEF one cycle later.
        set_req(0, 1'b1, 32'h0000_0010, 32'h0, 1'b0, BMASK_WORD);
        tick();
        req[0] = 1'b0;
        ld_ovr = 1'b1;
        ld_ovr_val = 32'hDEAD_BEEF;
        tick();
        chk("p0_read_data", 64'(obs_rd0), 64'hDEAD_BEEF);
        idle(3);

        // Port 1 byte write contending with a port 0 read.
        set_req(0, 1'b1, 32'h0000_0020, 32'h0, 1'b0, BMASK_WORD);
        set_req(1, 1'b1, 32'h0000_7000, 32'h0000_00FF, 1'b1, BMASK_BYTE);
        wcnt1 = 0; wcnt3 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            wcnt1 += int'(obs_wren1);
            wcnt3 += int'(obs_wren3);
            if (last_wv) req[last_w] = 1'b0;
        end
        chk("p1_write_once_d1", 64'(wcnt1), 64'd1);
        chk("p1_write_once_d3", 64'(wcnt3), 64'd1);

`ifdef LSU_ARB_FIXED_PRIO_EN
        // Both ports request continuously; port 1 must break in after STARVE_LIM.
        do_reset();
        set_req(0, 1'b1, 32'h0000_1000, 32'h0, 1'b0, BMASK_WORD);
        set_req(1, 1'b1, 32'h0000_2000, 32'h0, 1'b0, BMASK_WORD);
        p0_run = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_p1gnt) begin
                chk("starve_run", 64'(p0_run), 64'(STARVE_LIM));
                p0_run = 0;
            end else begin
                p0_run++;
            end
        end
        idle(4);
`else
        p0_run = 0;
`endif

        // Reset while a port 0 read is in flight.
        set_req(0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, BMASK_WORD);
        tick();
        do_reset();
        idle(5);

        // Random traffic honouring hold-until-grant, with occasional drops.
        for (int i = 0; i < 300; i++) begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(p, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                                3'($urandom_range(0, 5)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
            end
            tick();
            if (last_wv) req[last_w] = 1'b0;
        end
        idle(5);
        chk("sb1_empty", 64'(sb1.size()), 64'd0);
        chk("sb3_empty", 64'(sb3.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
